snow64_float_int_cast_unit: RTL

SNOW64_FLOAT_INT_CAST_UNIT -- requirements
Module: snow64_float_int_cast_unit

---
 rtl/snow64_float_int_cast_unit.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/snow64_float_int_cast_unit.sv
// Float <-> integer conversion unit.
// Accepts one command in IDLE, normalizes in NORM, rounds/saturates in ROUND,
// then holds the result in DONE until the consumer acknowledges it.
module snow64_float_int_cast_unit #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 7
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_start,
    input  logic                            in_dir,
    input  logic                            in_round_mode,
    input  logic [1:0]                      in_int_type_size,
    input  logic                            in_type_signedness,
    input  logic [63:0]                     in_int_data,
    input  logic [EXP_WIDTH+MANT_WIDTH:0]   in_float_data,
    input  logic                            in_result_ack,
    output logic                            out_can_accept_cmd,
    output logic                            out_valid,
    output logic [63:0]                     out_int_data,
    output logic [EXP_WIDTH+MANT_WIDTH:0]   out_float_data,
    output logic                            out_inexact,
    output logic                            out_overflow
);
    localparam int FW   = 1 + EXP_WIDTH + MANT_WIDTH;
    localparam int BIAS = (1 << (EXP_WIDTH - 1)) - 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_NORM  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]  state;
    logic        accept;

    // captured command
    logic        c_dir, c_rm, c_sg;
    logic [1:0]  c_sz;
    logic [63:0] c_int;
    logic [FW-1:0] c_flt;

    // NORM-stage results (shared between directions)
    logic                 n_sign, n_zero, n_guard, n_sticky;
    logic                 n_nan, n_inf, n_huge, n_mnz;
    logic [EXP_WIDTH-1:0] n_exp;
    logic [63:0]          n_mag;

    assign out_can_accept_cmd = (state == ST_IDLE);
    assign out_valid          = (state == ST_DONE);
    assign accept             = in_start && out_can_accept_cmd;

    // FSM sequencing; ack only matters while the result is presented
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (accept) state <= ST_NORM;
                ST_NORM:  state <= ST_ROUND;
                ST_ROUND: state <= ST_DONE;
                default:  if (in_result_ack) state <= ST_IDLE;
            endcase
        end
    end

    // operand capture on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_dir <= 1'b0; c_rm <= 1'b0; c_sg <= 1'b0; c_sz <= 2'd0;
            c_int <= '0;   c_flt <= '0;
        end else if (accept) begin
            c_dir <= in_dir;
            c_rm  <= in_round_mode;
            c_sg  <= in_type_signedness;
            c_sz  <= in_int_type_size;
            c_int <= in_int_data;
            c_flt <= in_float_data;
        end
    end

    // ---------------- NORM combinational ----------------
    logic [63:0]          i_ext, i_mag, i_norm;
    logic                 i_neg;
    logic [6:0]           i_clz;
    logic [EXP_WIDTH-1:0] i_exp;

    logic                 f_sign, f_nan, f_inf, f_zero, f_huge, f_tiny;
    logic [EXP_WIDTH-1:0] f_exp;
    logic [MANT_WIDTH-1:0] f_mant;
    int                   f_unb;
    logic [127:0]         f_wk;

    // int->float: extend to 64 bits, take magnitude, find leading one
    always_comb begin
        case (c_sz)
            2'd0:    i_ext = c_sg ? {{56{c_int[7]}},  c_int[7:0]}  : {56'd0, c_int[7:0]};
            2'd1:    i_ext = c_sg ? {{48{c_int[15]}}, c_int[15:0]} : {48'd0, c_int[15:0]};
            2'd2:    i_ext = c_sg ? {{32{c_int[31]}}, c_int[31:0]} : {32'd0, c_int[31:0]};
            default: i_ext = c_int;
        endcase
        i_neg = c_sg & i_ext[63];
        i_mag = i_neg ? (~i_ext + 64'd1) : i_ext;
        i_clz = 7'd64;
        for (int b = 0; b < 64; b++)
            if (i_mag[b]) i_clz = 7'(63 - b);
        i_norm = i_mag << i_clz[5:0];
        i_exp  = EXP_WIDTH'(BIAS + 63 - int'(i_clz));
    end

    // float->int: place {1,mant} in a 64.64 fixed-point window
    always_comb begin
        f_sign = c_flt[FW-1];
        f_exp  = c_flt[FW-2 -: EXP_WIDTH];
        f_mant = c_flt[MANT_WIDTH-1:0];
        f_nan  = (&f_exp) & (|f_mant);
        f_inf  = (&f_exp) & ~(|f_mant);
        f_zero = ~(|f_exp);
        f_unb  = int'(f_exp) - BIAS;
        f_huge = (f_unb >= 64);
        f_tiny = (f_unb < -1);
        f_wk   = '0;
        if (!f_huge && !f_tiny)
            f_wk = {{(127 - MANT_WIDTH){1'b0}}, 1'b1, f_mant} << 7'(64 + f_unb - MANT_WIDTH);
    end

    // NORM -> ROUND pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_sign <= 1'b0; n_zero <= 1'b0; n_guard <= 1'b0; n_sticky <= 1'b0;
            n_nan <= 1'b0;  n_inf <= 1'b0;  n_huge <= 1'b0;  n_mnz <= 1'b0;
            n_exp <= '0;    n_mag <= '0;
        end else if (state == ST_NORM) begin
            if (!c_dir) begin
                n_sign   <= i_neg;
                n_zero   <= (i_mag == 64'd0);
                n_exp    <= i_exp;
                n_mag    <= i_norm;
                n_guard  <= 1'b0;
                n_sticky <= 1'b0;
                n_nan    <= 1'b0;
                n_inf    <= 1'b0;
                n_huge   <= 1'b0;
                n_mnz    <= 1'b0;
            end else begin
                n_sign   <= f_sign;
                n_zero   <= f_zero;
                n_exp    <= f_exp;
                n_mag    <= f_wk[127:64];
                n_guard  <= f_wk[63];
                n_sticky <= (|f_wk[62:0]) | f_tiny;
                n_nan    <= f_nan;
                n_inf    <= f_inf;
                n_huge   <= f_huge;
                n_mnz    <= |f_mant;
            end
        end
    end

    // ---------------- ROUND combinational ----------------
    logic                  i_g, i_s, i_inc;
    logic [MANT_WIDTH:0]   i_msum;
    logic [EXP_WIDTH-1:0]  i_rexp;
    logic [FW-1:0]         r_float;
    logic                  r_f_inx;

    // int->float: round-nearest-even on the bits below the kept mantissa
    always_comb begin
        i_g     = n_mag[62 - MANT_WIDTH];
        i_s     = |(n_mag << (MANT_WIDTH + 2));
        i_inc   = c_rm & i_g & (i_s | n_mag[63 - MANT_WIDTH]);
        i_msum  = {1'b0, n_mag[62 -: MANT_WIDTH]} + (MANT_WIDTH+1)'(i_inc);
        i_rexp  = n_exp + EXP_WIDTH'(i_msum[MANT_WIDTH]);
        r_float = n_zero ? '0 : {n_sign, i_rexp, i_msum[MANT_WIDTH-1:0]};
        r_f_inx = ~n_zero & (i_g | i_s);
    end

    logic        f_inc, f_big;
    logic [64:0] f_rmag, f_half, f_umax, f_smax;
    logic [63:0] r_int;
    logic        r_i_inx, r_i_ovf;

    // float->int: round, range-check against the selected type, saturate
    always_comb begin
        f_half  = 65'd1 << ((32'd8 << c_sz) - 32'd1);
        f_umax  = (65'd1 << (32'd8 << c_sz)) - 65'd1;
        f_smax  = f_half - 65'd1;
        f_inc   = c_rm & n_guard & (n_sticky | n_mag[0]);
        f_rmag  = {1'b0, n_mag} + 65'(f_inc);
        f_big   = n_huge | n_inf;
        r_int   = '0;
        r_i_inx = 1'b0;
        r_i_ovf = 1'b0;
        if (n_nan) begin
            r_i_ovf = 1'b1;
        end else if (n_zero) begin
            r_i_inx = n_mnz;
        end else begin
            r_i_inx = n_guard | n_sticky;
            if (!n_sign) begin
                r_i_ovf = f_big | (f_rmag > (c_sg ? f_smax : f_umax));
                r_int   = r_i_ovf ? (c_sg ? f_smax[63:0] : f_umax[63:0]) : f_rmag[63:0];
            end else if (c_sg) begin
                r_i_ovf = f_big | (f_rmag > f_half);
                r_int   = r_i_ovf ? (~f_half[63:0] + 64'd1) : (~f_rmag[63:0] + 64'd1);
            end else begin
                r_i_ovf = f_big | (f_rmag != 65'd0);
            end
        end
    end

    // result registers, loaded on ROUND->DONE; unused direction port is zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_int_data   <= '0;
            out_float_data <= '0;
            out_inexact    <= 1'b0;
            out_overflow   <= 1'b0;
        end else if (state == ST_ROUND) begin
            out_int_data   <= c_dir ? r_int : 64'd0;
            out_float_data <= c_dir ? '0 : r_float;
            out_inexact    <= c_dir ? r_i_inx : r_f_inx;
            out_overflow   <= c_dir ? r_i_ovf : 1'b0;
        end
    end
endmodule
